axi_slave_mem: RTL
==================

// Module: axi_slave_mem
// PURPOSE
//  AXI4 slave responder with on-chip word-addressed memory: the far end of the AXI master driven through axi_interface.
//  Accepts AW/W/B and AR/R traffic, stores write data with byte strobes and returns read bursts.
//  Serves as the DUT-side target in the AXI bench, so master RTL can be checked end to end against the interface SVA.
//  One outstanding write and one outstanding read; write and read channels run independently.
// PARAMETERS
//  ID_WIDTH     4   AXI ID width (aw/b/ar/r)
//  ADDR_WIDTH   32  byte address width
//  DATA_WIDTH   32  data bus width, power of 2, >=8
//  LEN_WIDTH    8   awlen/arlen width (beats-1)
//  SIZE_WIDTH   3   awsize/arsize width
//  BURST_WIDTH  2   awburst/arburst width
//  MEM_AW       10  log2 of memory depth in DATA_WIDTH words
// PORTS
//  clk      in   1             clock, all logic on posedge
//  rst      in   1             synchronous active-high reset
//  awid/awaddr/awlen/awsize/awburst  in  per param  write address
//  awvalid  in   1  ; awready out 1
//  wdata    in   DATA_WIDTH ; wstrb in DATA_WIDTH/8 ; wlast in 1 ; wvalid in 1 ; wready out 1
//  bid      out  ID_WIDTH ; bresp out 2 ; bvalid out 1 ; bready in 1
//  arid/araddr/arlen/arsize/arburst  in  per param  read address
//  arvalid  in   1  ; arready out 1
//  rid      out  ID_WIDTH ; rdata out DATA_WIDTH ; rresp out 2 ; rlast out 1 ; rvalid out 1 ; rready in 1
// BEHAVIOUR
//  - Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid/rid/bresp/rresp/rdata=0; memory not reset.
//  - Reset mid-burst aborts both FSMs to IDLE; partial write beats already stored stay stored.
//  - Word index = addr[MEM_AW+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; upper address bits ignored (aliasing).
//  - Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//    W_IDLE: awready=1; on awvalid&&awready latch id/addr/len/size/burst, beat_cnt=0, go W_DATA (wready=1 next cycle).
//    W_DATA: awready=0, wready=1; each wvalid&&wready writes bytes where wstrb[i]=1, advances addr, beat_cnt++.
//            Beat with beat_cnt==len ends burst -> W_RESP next cycle (wready=0).
//    W_RESP: bvalid=1, bid=latched id; hold bresp/bid stable until bready; on handshake -> W_IDLE, awready=1 next cycle.
//  - Read FSM R_IDLE -> R_DATA -> R_IDLE:
//    R_IDLE: arready=1; on handshake latch ctrl, load rdata=mem[addr], rvalid=1 next cycle (latency 1).
//    R_DATA: arready=0; rid/rdata/rresp/rlast stable while rvalid&&!rready; on handshake load next beat.
//            rlast=1 only on beat len; handshake on last beat -> R_IDLE, rvalid=0, arready=1 next cycle.
//  - Address update per beat: FIXED(0) addr unchanged; INCR(1) addr += 1<<size;
//    WRAP(2) addr += 1<<size, wrapping within aligned block of (len+1)<<size bytes.
//  - Error -> SLVERR(2'b10), no memory write, reads return rdata=0, burst still runs full len+1 beats:
//    burst==3; size > log2(DATA_WIDTH/8); WRAP with len not in {1,3,7,15}. Otherwise OKAY(2'b00).
//  - Same-cycle read load and write to same word: read returns old data.
//  - Back-to-back: an AW handshake cannot occur in the cycle bvalid&&bready completes (awready rises next cycle).
// CONFIGURATION
//  AXI_SLV_WLAST_CHK_EN defined: wlast=1 on beat != len, or wlast=0 on beat len, sets sticky error -> bresp=SLVERR
//    (data beats still written; burst still ends on beat count). Error clears on entering W_IDLE.
//  Not defined: wlast ignored, burst end by beat count only, bresp per error rules above.
// TESTING
//  1 Single write: aw addr=0x10 len=0 size=2 INCR, w data=0xDEADBEEF strb=4'hF -> bvalid 1 cycle after W beat, bresp=0, bid=awid.
//  2 INCR read-back: ar addr=0x10 len=3 size=2 after writing 0x10..0x1C = 1,2,3,4 -> rdata 1,2,3,4, rlast only on 4th, rvalid 1 cycle after AR.
//  3 WRAP: write words 0x00..0x0C = A,B,C,D; ar addr=0x08 len=3 WRAP -> rdata C,D,A,B.
//  4 Strobe + backpressure: write 0xFFFFFFFF then 0x11223344 strb=4'b0101 with rready toggling -> read 0xFF22FF44; rdata stable while stalled.
//  5 Errors: awburst=3 -> bresp=2'b10, memory unchanged; arsize=3 -> 1+len beats rresp=2'b10 rdata=0.
//  6 rst=1 in W_DATA after 2 of 4 beats -> next cycle awready=1, wready=0, bvalid=0; new write completes normally.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI4 slave with word-addressed on-chip memory; one outstanding write and one outstanding read, channels independent.
// Optional AXI_SLV_WLAST_CHK_EN: a wlast/beat-count disagreement makes bresp SLVERR.
module axi_slave_mem #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2,
  parameter int MEM_AW      = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [SIZE_WIDTH-1:0]   awsize,
  input  logic [BURST_WIDTH-1:0]  awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [LEN_WIDTH-1:0]    arlen,
  input  logic [SIZE_WIDTH-1:0]   arsize,
  input  logic [BURST_WIDTH-1:0]  arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] OKAY   = 2'b00;

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

  function automatic logic [MEM_AW-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] s;
    s = a >> OFF_W;
    return s[MEM_AW-1:0];
  endfunction

  function automatic logic bad_ctrl(input logic [LEN_WIDTH-1:0] len,
                                    input logic [SIZE_WIDTH-1:0] size,
                                    input logic [BURST_WIDTH-1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                  (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    return (burst == BURST_WIDTH'(3)) || (int'(size) > OFF_W) ||
           ((burst == BURST_WIDTH'(2)) && !wrap_len_ok);
  endfunction

  // WRAP keeps the upper bits of the aligned (len+1)<<size block and wraps the offset.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [LEN_WIDTH-1:0] len,
                                                      input logic [SIZE_WIDTH-1:0] size,
                                                      input logic [BURST_WIDTH-1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask, nxt;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    nxt  = a + step;
    case (burst)
      BURST_WIDTH'(0): return a;
      BURST_WIDTH'(2): return (a & ~mask) | (nxt & mask);
      default:         return nxt;
    endcase
  endfunction

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t w_state, w_next;

  logic [ID_WIDTH-1:0]    w_id;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [LEN_WIDTH-1:0]   w_len, w_cnt;
  logic [SIZE_WIDTH-1:0]  w_size;
  logic [BURST_WIDTH-1:0] w_burst;
  logic                   w_err, wl_err;

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (w_cnt == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (w_state == W_IDLE && awvalid) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_cnt   <= '0;
      w_size  <= awsize;
      w_burst <= awburst;
      w_err   <= bad_ctrl(awlen, awsize, awburst);
    end else if (w_state == W_DATA && wvalid) begin
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
      w_cnt  <= w_cnt + LEN_WIDTH'(1);
    end
  end

`ifdef AXI_SLV_WLAST_CHK_EN
  always_ff @(posedge clk) begin
    if (rst || w_state == W_IDLE)
      wl_err <= 1'b0;
    else if (w_state == W_DATA && wvalid && (wlast != (w_cnt == w_len)))
      wl_err <= 1'b1;
  end
`else
  logic unused_wlast;
  assign unused_wlast = wlast;
  assign wl_err = 1'b0;
`endif

  assign bid   = w_id;
  assign bresp = (w_state == W_RESP && (w_err || wl_err)) ? SLVERR : OKAY;

  // Memory itself is never reset; a beat presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_state == W_DATA && wvalid && !w_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  rstate_t r_state, r_next;

  logic [ADDR_WIDTH-1:0]  r_addr, r_addr_nxt;
  logic [LEN_WIDTH-1:0]   r_len, r_cnt;
  logic [SIZE_WIDTH-1:0]  r_size;
  logic [BURST_WIDTH-1:0] r_burst;
  logic [ID_WIDTH-1:0]    r_id;
  logic                   r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign r_addr_nxt = next_addr(r_addr, r_len, r_size, r_burst);

  // Non-blocking memory read: a same-cycle write to the word is seen by the next load only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      rdata   <= '0;
      rlast   <= 1'b0;
    end else if (r_state == R_IDLE && arvalid) begin
      r_id    <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_cnt   <= '0;
      r_size  <= arsize;
      r_burst <= arburst;
      r_err   <= bad_ctrl(arlen, arsize, arburst);
      rdata   <= bad_ctrl(arlen, arsize, arburst) ? '0 : mem[widx(araddr)];
      rlast   <= (arlen == '0);
    end else if (r_state == R_DATA && rready) begin
      if (rlast) begin
        rlast <= 1'b0;
      end else begin
        r_addr <= r_addr_nxt;
        r_cnt  <= r_cnt + LEN_WIDTH'(1);
        rdata  <= r_err ? '0 : mem[widx(r_addr_nxt)];
        rlast  <= ((r_cnt + LEN_WIDTH'(1)) == r_len);
      end
    end
  end

  assign rid   = r_id;
  assign rresp = (rvalid && r_err) ? SLVERR : OKAY;

endmodule
